// File: rtl/tdm_receive_multi.sv
// TDM serial-audio receiver: SLOTS x SLOT_WIDTH-bit slots per frame, SAMPLE_WIDTH MSB-first bits each, frame-sync tracked.
// Optional frame-sync error reporting via macro TDM_RX_FRAME_CHECK_EN (otherwise frame_err_out stays 0).
module tdm_receive_multi #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SLOTS        = 4,
  parameter int FRAME_DELAY  = 1,
  localparam int SLOT_BITS   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                    sck,
  input  logic                    rst_n_in,
  input  logic                    ws,
  input  logic                    sd,
  output logic [SAMPLE_WIDTH-1:0] audio_out,
  output logic [SLOT_BITS-1:0]    slot_out,
  output logic                    audio_valid_out,
  output logic                    locked_out,
  output logic                    frame_err_out
);

  localparam int BIT_BITS = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [BIT_BITS-1:0]  BIT_LAST  = BIT_BITS'(SLOT_WIDTH - 1);
  localparam logic [BIT_BITS-1:0]  SMP_LAST  = BIT_BITS'(SAMPLE_WIDTH - 1);
  localparam logic [BIT_BITS-1:0]  BIT_ONE   = BIT_BITS'(1);
  localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(SLOTS - 1);
  localparam logic [SLOT_BITS-1:0] SLOT_ONE  = SLOT_BITS'(1);
`ifdef TDM_RX_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > SLOT_WIDTH || SLOTS < 1 ||
      (FRAME_DELAY != 0 && FRAME_DELAY != 1)) begin : g_bad_params
    $error("tdm_receive_multi: illegal parameter combination");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic                    ws_q;
  logic [BIT_BITS-1:0]     bit_cnt;
  logic [SLOT_BITS-1:0]    slot_cnt;
  logic [SAMPLE_WIDTH-1:0] shift;
  logic [SAMPLE_WIDTH-1:0] shift_nxt;
  logic                    rise;
  logic                    expect_edge;
  logic                    do_proc;
  logic                    clear;
  logic                    drop;
  logic                    err;
  logic [BIT_BITS-1:0]     proc_bit;
  logic [SLOT_BITS-1:0]    proc_slot;

  assign rise      = ws & ~ws_q;
  assign shift_nxt = (shift << 1) | SAMPLE_WIDTH'(sd);

  // With a one-cycle delay the frame boundary falls on the last bit of the last slot;
  // without it, on the edge that would sample bit 0 of the next frame (counters wrapped to 0).
  assign expect_edge = (state == RUN) &&
                       ((FRAME_DELAY == 1) ? (bit_cnt == BIT_LAST && slot_cnt == SLOT_LAST)
                                           : (bit_cnt == '0 && slot_cnt == '0));

  always_comb begin
    do_proc   = 1'b0;
    clear     = 1'b0;
    drop      = 1'b0;
    err       = 1'b0;
    proc_bit  = bit_cnt;
    proc_slot = slot_cnt;
    if (rise && (state == IDLE || !expect_edge)) begin
      // (Re)start: any partial slot is abandoned; without delay this edge carries slot-0 MSB.
      err   = CHECK_EN && (state == RUN);
      clear = 1'b1;
      if (FRAME_DELAY == 0) begin
        do_proc   = 1'b1;
        proc_bit  = '0;
        proc_slot = '0;
      end
    end else if (state == RUN) begin
      if (expect_edge && !rise) begin
        drop    = 1'b1;
        err     = CHECK_EN;
        do_proc = (FRAME_DELAY == 1);
      end else begin
        do_proc = 1'b1;
      end
    end
  end

  always_ff @(posedge sck or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      ws_q            <= 1'b1;
      bit_cnt         <= '0;
      slot_cnt        <= '0;
      shift           <= '0;
      audio_out       <= '0;
      slot_out        <= '0;
      audio_valid_out <= 1'b0;
      locked_out      <= 1'b0;
      frame_err_out   <= 1'b0;
    end else begin
      ws_q            <= ws;
      frame_err_out   <= err;
      audio_valid_out <= 1'b0;
      if (drop) begin
        state      <= IDLE;
        locked_out <= 1'b0;
      end else if (clear) begin
        state      <= RUN;
        locked_out <= 1'b1;
      end
      if (do_proc) begin
        if (proc_bit <= SMP_LAST) begin
          shift <= shift_nxt;
        end
        if (proc_bit == SMP_LAST) begin
          audio_out       <= shift_nxt;
          slot_out        <= proc_slot;
          audio_valid_out <= 1'b1;
        end
        if (proc_bit == BIT_LAST) begin
          bit_cnt  <= '0;
          slot_cnt <= (proc_slot == SLOT_LAST) ? '0 : proc_slot + SLOT_ONE;
        end else begin
          bit_cnt  <= proc_bit + BIT_ONE;
          slot_cnt <= proc_slot;
        end
      end else if (clear) begin
        bit_cnt  <= '0;
        slot_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_receive_multi.sv
// Bench: two receiver configurations (delayed 24/32x4 and undelayed 16/16x8) on a shared ws/reset stream.
module tb_tdm_receive_multi;

  localparam int N = 860;

  logic        sck;
  logic        rst_n;
  logic        ws;
  logic        sd_a;
  logic        sd_b;
  logic [23:0] audio_a;
  logic [1:0]  slot_a;
  logic        vld_a, lock_a, err_a;
  logic [15:0] audio_b;
  logic [2:0]  slot_b;
  logic        vld_b, lock_b, err_b;

  tdm_receive_multi u_a (
    .sck(sck), .rst_n_in(rst_n), .ws(ws), .sd(sd_a),
    .audio_out(audio_a), .slot_out(slot_a), .audio_valid_out(vld_a),
    .locked_out(lock_a), .frame_err_out(err_a)
  );

  tdm_receive_multi #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .SLOTS(8), .FRAME_DELAY(0)) u_b (
    .sck(sck), .rst_n_in(rst_n), .ws(ws), .sd(sd_b),
    .audio_out(audio_b), .slot_out(slot_b), .audio_valid_out(vld_b),
    .locked_out(lock_b), .frame_err_out(err_b)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

`ifdef TDM_RX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic        ws_v   [N];
  logic        sd_v   [2][N];
  bit          in_rst [N];
  bit          ev     [2][N];
  bit          ee     [2][N];
  bit          el     [2][N];
  logic [31:0] ew     [2][N];
  int          es     [2][N];
  logic [23:0] dw     [4];

  function automatic int p_sw(int d);  return (d == 0) ? 24 : 16; endfunction
  function automatic int p_slw(int d); return (d == 0) ? 32 : 16; endfunction
  function automatic int p_sl(int d);  return (d == 0) ? 4 : 8;   endfunction
  function automatic int p_fd(int d);  return (d == 0) ? 1 : 0;   endfunction

  // First ws rise at index >= from inside segment [s,t); reset leaves ws history "high".
  function automatic int next_rise(int from, int s, int t);
    for (int e = from; e < t; e++)
      if (e > s && ws_v[e] && !ws_v[e-1]) return e;
    return -1;
  endfunction

  // Frame-level reference: each rise opens a frame of SLOTS*SLOT_WIDTH edges.
  task automatic model_seg(input int d, input int s, input int t);
    int sw, slw, sl, fd, r, e_end, x, hit, l, lim, base;
    logic [31:0] w;
    bit ok;
    sw = p_sw(d); slw = p_slw(d); sl = p_sl(d); fd = p_fd(d);
    r = next_rise(s, s, t);
    while (r >= 0) begin
      e_end = r + sl * slw;
      x     = next_rise(r + 1, s, t);
      hit   = (x >= 0 && x <= e_end) ? x : -1;
      for (int k = 0; k < sl; k++) begin
        base = r + fd + k * slw;
        l    = base + sw - 1;
        ok   = (hit >= 0 && hit < e_end) ? (l < hit) : (l <= e_end);
        if (ok && l < t) begin
          w = '0;
          for (int i = 0; i < sw; i++) w = (w << 1) | 32'(sd_v[d][base + i]);
          ev[d][l] = 1'b1;
          ew[d][l] = w;
          es[d][l] = k;
        end
      end
      lim = (hit >= 0) ? hit : e_end;
      for (int e = r; e < lim && e < t; e++) el[d][e] = 1'b1;
      if (hit >= 0) begin
        if (hit < e_end) ee[d][hit] = CHK;
        r = hit;
      end else begin
        if (e_end < t) ee[d][e_end] = CHK;
        r = x;
      end
    end
  endtask

  task automatic build_expect(input int d);
    int s, t;
    logic [31:0] cw;
    int cs;
    for (int e = 0; e < N; e++) begin
      ev[d][e] = 0; ee[d][e] = 0; el[d][e] = 0; ew[d][e] = '0; es[d][e] = 0;
    end
    s = 0;
    while (s < N) begin
      if (in_rst[s]) begin
        s++;
      end else begin
        t = s;
        while (t < N && !in_rst[t]) t++;
        model_seg(d, s, t);
        s = t;
      end
    end
    cw = '0; cs = 0;
    for (int e = 0; e < N; e++) begin
      if (in_rst[e]) begin
        cw = '0; cs = 0;
      end else if (ev[d][e]) begin
        cw = ew[d][e]; cs = es[d][e];
      end
      ew[d][e] = cw;
      es[d][e] = cs;
    end
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic chk_zero(input int e);
    chk("a_rst_audio", e, 32'(audio_a), 32'd0);
    chk("a_rst_slot",  e, 32'(slot_a),  32'd0);
    chk("a_rst_vld",   e, 32'(vld_a),   32'd0);
    chk("a_rst_lock",  e, 32'(lock_a),  32'd0);
    chk("a_rst_err",   e, 32'(err_a),   32'd0);
    chk("b_rst_audio", e, 32'(audio_b), 32'd0);
    chk("b_rst_slot",  e, 32'(slot_b),  32'd0);
    chk("b_rst_vld",   e, 32'(vld_b),   32'd0);
    chk("b_rst_lock",  e, 32'(lock_b),  32'd0);
    chk("b_rst_err",   e, 32'(err_b),   32'd0);
  endtask

  task automatic apply(input int e);
    rst_n = !in_rst[e];
    ws    = ws_v[e];
    sd_a  = sd_v[0][e];
    sd_b  = sd_v[1][e];
    if (in_rst[e] && (e == 0 || !in_rst[e-1])) begin
      #1;
      chk_zero(e);
    end
  endtask

  task automatic check_edge(input int e);
    chk("a_vld",   e, 32'(vld_a),   32'(ev[0][e]));
    chk("a_err",   e, 32'(err_a),   32'(ee[0][e]));
    chk("a_lock",  e, 32'(lock_a),  32'(el[0][e]));
    chk("a_audio", e, 32'(audio_a), ew[0][e]);
    chk("a_slot",  e, 32'(slot_a),  32'(es[0][e]));
    chk("b_vld",   e, 32'(vld_b),   32'(ev[1][e]));
    chk("b_err",   e, 32'(err_b),   32'(ee[1][e]));
    chk("b_lock",  e, 32'(lock_b),  32'(el[1][e]));
    chk("b_audio", e, 32'(audio_b), ew[1][e]);
    chk("b_slot",  e, 32'(slot_b),  32'(es[1][e]));
  endtask

  initial begin
    int rises [6];
    rst_n = 1'b0; ws = 1'b1; sd_a = 1'b0; sd_b = 1'b0;

    // Stimulus: ws high through reset, periodic frames, a mid-frame rise,
    // a withheld rise, a reset mid-slot-1, then recovery.
    rises = '{10, 138, 266, 394, 469, 620};
    for (int e = 0; e < N; e++) begin
      ws_v[e]   = (e < 6);
      in_rst[e] = (e >= 658 && e <= 660);
      sd_v[0][e] = 1'($urandom_range(0, 1));
      sd_v[1][e] = 1'($urandom_range(0, 1));
    end
    foreach (rises[j])
      for (int i = 0; i < 4; i++) ws_v[rises[j] + i] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ws_v[700 + i] = 1'b1;
      ws_v[828 + i] = 1'b1;
    end
    dw[0] = 24'hABCDEF; dw[1] = 24'h123456; dw[2] = 24'h800001; dw[3] = 24'h7FFFFF;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 32; i++)
        sd_v[0][11 + k * 32 + i] = (i < 24) ? dw[k][23 - i] : 1'b0;

    build_expect(0);
    build_expect(1);

    #2;
    chk_zero(-1);
    @(negedge sck);
    apply(0);
    for (int e = 0; e < N; e++) begin
      @(negedge sck);
      check_edge(e);
      if (e + 1 < N) apply(e + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
